spi_frame_receiver: RTL and testbench

Receiving end of the 40-bit register-write SPI link, which uses SPI mode 0 with MSB first. The block samples `spi_cs_l`, `spi_sclk` and `spi_data` with the system clock and deserializes each frame. It checks the frame's fixed header and marker bytes, then presents the 16-bit address and 8-bit data with a one-cycle valid strobe. It sits at the register-file side of the link, typically in loopback with the frame transmitter for bring-up.

---
 rtl/spi_frame_receiver.sv | 186 ++++++++++++++++++
 tb/tb_spi_frame_receiver.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module   : spi_frame_receiver
// Brief    : Mode-0 SPI deserializer for 40-bit register-write frames.
//            Define SPI_RX_SYNC_EN for two-flop input synchronizers.
// Revision : 1.0
// ============================================================================
module spi_frame_receiver #(
  parameter int         FRAME_BITS = 40,
  parameter logic [7:0] HEADER     = 8'hFF,
  parameter logic [7:0] MARKER     = 8'h01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_cs_l,
  input  logic        spi_sclk,
  input  logic        spi_data,
  output logic [15:0] rx_addr,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_err,
  output logic [1:0]  err_code,
  output logic        busy
);

  localparam int              CW     = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0]   c_last = CW'(FRAME_BITS - 1);

  localparam logic [1:0] c_sync  = 2'd0;
  localparam logic [1:0] c_idle  = 2'd1;
  localparam logic [1:0] c_shift = 2'd2;
  localparam logic [1:0] c_done  = 2'd3;

  // Sampled {cs_l, sclk, data}; cs sample resets low so SYNC waits for a real idle level
  logic [2:0] smp_q;

`ifdef SPI_RX_SYNC_EN
  logic [2:0] meta_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 3'b000;
      smp_q  <= 3'b000;
    end else begin
      meta_q <= {spi_cs_l, spi_sclk, spi_data};
      smp_q  <= meta_q;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      smp_q <= 3'b000;
    end else begin
      smp_q <= {spi_cs_l, spi_sclk, spi_data};
    end
  end
`endif

  logic w_cs, w_sclk, w_data;
  logic w_cs_fall, w_cs_rise, w_sclk_rise;
  logic cs_p_q, sclk_p_q;

  assign w_cs        = smp_q[2];
  assign w_sclk      = smp_q[1];
  assign w_data      = smp_q[0];
  assign w_cs_fall   = cs_p_q & ~w_cs;
  assign w_cs_rise   = ~cs_p_q & w_cs;
  assign w_sclk_rise = ~sclk_p_q & w_sclk;

  logic [1:0]            state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ovr_q, ovr_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic [1:0]            code_q, code_d;
  logic [15:0]           addr_q, addr_d;
  logic [7:0]            data_q, data_d;

  logic [7:0]  w_hdr, w_mrk, w_dat;
  logic [15:0] w_adr;

  assign w_hdr = shift_q[FRAME_BITS-1 -: 8];
  assign w_adr = shift_q[FRAME_BITS-9 -: 16];
  assign w_mrk = shift_q[15:8];
  assign w_dat = shift_q[7:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= c_sync;
      cs_p_q   <= 1'b1;
      sclk_p_q <= 1'b0;
      shift_q  <= '0;
      cnt_q    <= '0;
      ovr_q    <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= 2'd0;
      addr_q   <= 16'h0000;
      data_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      cs_p_q   <= w_cs;
      sclk_p_q <= w_sclk;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      ovr_q    <= ovr_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      code_q   <= code_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  // cs_rise outranks a coincident sclk_rise in SHIFT and DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_sync:  if (w_cs) state_d = c_idle;
      c_idle:  if (w_cs_fall) state_d = c_shift;
      c_shift: begin
        if (w_cs_rise)                           state_d = c_idle;
        else if (w_sclk_rise && cnt_q == c_last) state_d = c_done;
      end
      c_done:  if (w_cs_rise) state_d = c_idle;
      default: state_d = c_sync;
    endcase
  end

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    addr_d  = addr_q;
    data_d  = data_q;
    busy    = (state_q == c_shift) || (state_q == c_done);
    case (state_q)
      c_idle: begin
        if (w_cs_fall) begin
          shift_d = '0;
          cnt_d   = '0;
          ovr_d   = 1'b0;
        end
      end
      c_shift: begin
        if (w_cs_rise) begin
          err_d  = 1'b1;
          code_d = 2'd1;
        end else if (w_sclk_rise) begin
          shift_d = {shift_q[FRAME_BITS-2:0], w_data};
          cnt_d   = cnt_q + CW'(1);
        end
      end
      c_done: begin
        if (w_cs_rise) begin
          if (ovr_q) begin
            err_d  = 1'b1;
            code_d = 2'd2;
          end else if (w_hdr != HEADER || w_mrk != MARKER) begin
            err_d  = 1'b1;
            code_d = 2'd3;
          end else begin
            valid_d = 1'b1;
            addr_d  = w_adr;
            data_d  = w_dat;
          end
        end else if (w_sclk_rise) begin
          ovr_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign rx_addr  = addr_q;
  assign rx_data  = data_q;
  assign rx_valid = valid_q;
  assign rx_err   = err_q;
  assign err_code = code_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_frame_receiver
// Brief    : Directed scoreboard bench for spi_frame_receiver (both builds).
// Revision : 1.0
// ============================================================================
module tb_spi_frame_receiver;

`ifdef SPI_RX_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        spi_cs_l = 1'b1;
  logic        spi_sclk = 1'b0;
  logic        spi_data = 1'b0;
  logic [15:0] rx_addr;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_err;
  logic [1:0]  err_code;
  logic        busy;

  spi_frame_receiver dut (
    .clk      (clk),
    .reset    (reset),
    .spi_cs_l (spi_cs_l),
    .spi_sclk (spi_sclk),
    .spi_data (spi_data),
    .rx_addr  (rx_addr),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_err   (rx_err),
    .err_code (err_code),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          valid;
    logic [1:0]  code;
    logic [15:0] addr;
    logic [7:0]  data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rcyc = 0;
  logic [15:0] m_addr = 16'h0000;
  logic [7:0]  m_data = 8'h00;
  logic [1:0]  m_code = 2'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; any strobe seen is matched against the oldest expected frame result
  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    if (rx_valid === 1'b1 || rx_err === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_strobe", {30'd0, rx_valid, rx_err}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rx_valid", 32'(rx_valid), 32'(e.valid));
        chk("rx_err", 32'(rx_err), 32'(!e.valid));
        chk("rx_addr", 32'(rx_addr), 32'(e.addr));
        chk("rx_data", 32'(rx_data), 32'(e.data));
        chk("err_code", 32'(err_code), 32'(e.code));
        chk("latency", cyc - e.cyc, LAT);
        chk("busy_at_strobe", 32'(busy), 32'd0);
      end
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  function automatic logic [39:0] mk(input logic [7:0] h, input logic [15:0] a,
                                     input logic [7:0] m, input logic [7:0] d);
    return {h, a, m, d};
  endfunction

  task automatic send(input logic [39:0] f, input int nbits, input int hp, input bit raise);
    spi_cs_l = 1'b0;
    ticks(2);
    for (int i = 0; i < nbits; i++) begin
      spi_data = (i < 40) ? f[39-i] : 1'b0;
      ticks(hp);
      spi_sclk = 1'b1;
      ticks(hp);
      spi_sclk = 1'b0;
      if (i == 4) chk("busy_mid_frame", 32'(busy), 32'd1);
    end
    ticks(1);
    if (raise) begin
      spi_cs_l = 1'b1;
      rcyc = cyc;
    end
  endtask

  task automatic expect_ok(input logic [15:0] a, input logic [7:0] d);
    m_addr = a;
    m_data = d;
    sb.push_back('{1'b1, m_code, a, d, rcyc});
  endtask

  task automatic expect_err(input logic [1:0] c);
    m_code = c;
    sb.push_back('{1'b0, c, m_addr, m_data, rcyc});
  endtask

  task automatic chk_reset_state();
    chk("rst_rx_addr", 32'(rx_addr), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_err", 32'(rx_err), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    ticks(3);
    chk_reset_state();
    reset = 1'b0;
    ticks(4);

    send(mk(8'hFF, 16'h1234, 8'h01, 8'hA5), 40, 1, 1'b1);
    expect_ok(16'h1234, 8'hA5);
    ticks(3);

    // Back-to-back frames with cs_l high for a single clock
    send(mk(8'hFF, 16'h0001, 8'h01, 8'h11), 40, 1, 1'b1);
    expect_ok(16'h0001, 8'h11);
    ticks(1);
    send(mk(8'hFF, 16'hBEEF, 8'h01, 8'h7E), 40, 2, 1'b1);
    expect_ok(16'hBEEF, 8'h7E);
    ticks(3);

    send(mk(8'hFE, 16'h1357, 8'h01, 8'h99), 40, 1, 1'b1);
    expect_err(2'd3);
    ticks(3);
    send(mk(8'hFF, 16'h2468, 8'h00, 8'h55), 40, 1, 1'b1);
    expect_err(2'd3);
    ticks(3);

    send(mk(8'hFF, 16'h4444, 8'h01, 8'h44), 20, 1, 1'b1);
    expect_err(2'd1);
    ticks(3);
    send(mk(8'hFF, 16'h5A5A, 8'h01, 8'hC3), 40, 2, 1'b1);
    expect_ok(16'h5A5A, 8'hC3);
    ticks(3);

    send(mk(8'hFF, 16'hCAFE, 8'h01, 8'h42), 41, 1, 1'b1);
    expect_err(2'd2);
    ticks(3);

    // Reset mid-frame; the truncated frame must never strobe
    send(mk(8'hFF, 16'h0F0F, 8'h01, 8'h77), 12, 1, 1'b0);
    reset = 1'b1;
    ticks(2);
    m_addr = 16'h0000;
    m_data = 8'h00;
    m_code = 2'd0;
    chk_reset_state();
    reset = 1'b0;
    ticks(3);
    spi_cs_l = 1'b1;
    ticks(4);
    send(mk(8'hFF, 16'h00FF, 8'h01, 8'h3C), 40, 1, 1'b1);
    expect_ok(16'h00FF, 8'h3C);
    ticks(6);

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
